irq_dispatcher: RTL and testbench

IRQ_DISPATCHER -- requirements
Module: irq_dispatcher

---
 rtl/irq_pkg.sv | 14 +
 rtl/irq_dispatcher_if.sv | 33 +++
 rtl/irq_fifo.sv | 61 ++++++
 rtl/irq_dispatcher.sv | 115 +++++++++++
 tb/tb_irq_dispatcher.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt dispatcher: default source count,
// ID width and the dispatcher state encoding.
package irq_pkg;

  localparam int NUM_INT_PORTS = 8;
  localparam int IW            = $clog2(NUM_INT_PORTS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SERVICE = 2'd2
  } irq_disp_state_t;

endpackage

// File: rtl/irq_dispatcher_if.sv
// Bus between the arbiter/core side and the dispatcher. The master side
// drives interrupt pulses and CPU handshakes; the slave side (the
// dispatcher) returns the presented/in-service IDs and queue status.
interface irq_dispatcher_if #(
  parameter int NUM_INT_PORTS = 8,
  parameter int FIFO_DEPTH    = 4
);

  localparam int IW = $clog2(NUM_INT_PORTS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          irq_vld;
  logic [IW-1:0] irq_id;
  logic          cpu_irq;
  logic [IW-1:0] cpu_irq_id;
  logic          cpu_ack;
  logic          cpu_eoi;
  logic [IW-1:0] in_svc_id;
  logic [CW-1:0] fifo_cnt;
  logic          ovf;
  logic          ovf_clr;

  modport master (
    output irq_vld, irq_id, cpu_ack, cpu_eoi, ovf_clr,
    input  cpu_irq, cpu_irq_id, in_svc_id, fifo_cnt, ovf
  );

  modport slave (
    input  irq_vld, irq_id, cpu_ack, cpu_eoi, ovf_clr,
    output cpu_irq, cpu_irq_id, in_svc_id, fifo_cnt, ovf
  );

endinterface

// File: rtl/irq_fifo.sv
// Small FIFO for queued interrupt IDs. A push while full is dropped unless a
// pop happens in the same cycle, in which case both are accepted. DEPTH must
// be a power of two so the pointers wrap naturally.
module irq_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW + 1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/irq_dispatcher.sv
// Interrupt dispatcher: queues granted interrupt IDs, presents the oldest to
// the core, tracks the one in service until EOI, and flags dropped pulses.
module irq_dispatcher
  import irq_pkg::*;
#(
  parameter int NUM_INT_PORTS = irq_pkg::NUM_INT_PORTS,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  irq_dispatcher_if.slave   bus
);

  localparam int ID_W = $clog2(NUM_INT_PORTS);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  irq_disp_state_t state_reg, state_next;
  logic            cpu_irq_reg, cpu_irq_next;
  logic [ID_W-1:0] cpu_irq_id_reg, cpu_irq_id_next;
  logic [ID_W-1:0] in_svc_id_reg, in_svc_id_next;
  logic            ovf_reg;

  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ID_W-1:0] fifo_head;
  logic [CW-1:0]   fifo_cnt;
  logic            overflow;

  // Only an ACK while presenting consumes the head entry.
  assign fifo_pop = (state_reg == PRESENT) && bus.cpu_ack;
  assign overflow = bus.irq_vld && fifo_full && !fifo_pop;

  irq_fifo #(
    .WIDTH (ID_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.irq_vld),
    .pop     (fifo_pop),
    .wr_data (bus.irq_id),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cpu_irq_reg    <= 1'b0;
      cpu_irq_id_reg <= '0;
      in_svc_id_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      cpu_irq_reg    <= cpu_irq_next;
      cpu_irq_id_reg <= cpu_irq_id_next;
      in_svc_id_reg  <= in_svc_id_next;
    end
  end

  // Next state and next output values; outputs follow the state being entered.
  always_comb begin
    state_next      = state_reg;
    in_svc_id_next  = in_svc_id_reg;
    cpu_irq_next    = 1'b0;
    cpu_irq_id_next = '0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) state_next = PRESENT;
      end
      PRESENT: begin
        if (bus.cpu_ack) begin
          state_next     = SERVICE;
          in_svc_id_next = cpu_irq_id_reg;
        end
      end
      SERVICE: begin
        if (bus.cpu_eoi) begin
          state_next     = IDLE;
          in_svc_id_next = '0;
        end
      end
      default: begin
        state_next     = IDLE;
        in_svc_id_next = '0;
      end
    endcase
    // The head is stable while presenting because only an ACK pops it.
    if (state_next == PRESENT) begin
      cpu_irq_next    = 1'b1;
      cpu_irq_id_next = fifo_head;
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (overflow) begin
      ovf_reg <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_reg <= 1'b0;
    end
  end

  assign bus.cpu_irq    = cpu_irq_reg;
  assign bus.cpu_irq_id = cpu_irq_id_reg;
  assign bus.in_svc_id  = in_svc_id_reg;
  assign bus.fifo_cnt   = fifo_cnt;
  assign bus.ovf        = ovf_reg;

endmodule

// File: tb/tb_irq_dispatcher.sv
// Directed bench for irq_dispatcher: a queue of expected IDs is filled as
// pulses are driven and drained as the core acknowledges presented IDs.
module tb_irq_dispatcher;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  irq_dispatcher_if #(.NUM_INT_PORTS(8), .FIFO_DEPTH(4)) bus ();

  irq_dispatcher #(.NUM_INT_PORTS(8), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-16s observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drive one pulse; the model queues it only if it will fit.
  task automatic push_id(input int id);
    bus.irq_vld = 1'b1;
    bus.irq_id  = id[2:0];
    if (exp_q.size() < 4) exp_q.push_back(id);
    tick();
    bus.irq_vld = 1'b0;
  endtask

  task automatic wait_present(output bit ok);
    for (int i = 0; i < 10 && !bus.cpu_irq; i++) tick();
    ok = bus.cpu_irq;
    if (!ok) chk("present_timeout", {31'd0, bus.cpu_irq}, 32'd1);
  endtask

  task automatic do_ack();
    bit ok;
    int id;
    wait_present(ok);
    if (!ok) return;
    id = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    chk("present_id", bus.cpu_irq_id, id);
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    chk("in_svc_id", bus.in_svc_id, id);
    chk("cnt_after_ack", bus.fifo_cnt, exp_q.size());
    chk("irq_low_in_svc", bus.cpu_irq, 0);
  endtask

  task automatic do_eoi();
    bus.cpu_eoi = 1'b1;
    tick();
    bus.cpu_eoi = 1'b0;
    chk("svc_clr_on_eoi", bus.in_svc_id, 0);
    chk("irq_low_on_eoi", bus.cpu_irq, 0);
  endtask

  initial begin
    int id;
    bus.irq_vld = 1'b0;
    bus.irq_id  = '0;
    bus.cpu_ack = 1'b0;
    bus.cpu_eoi = 1'b0;
    bus.ovf_clr = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_cpu_irq", bus.cpu_irq, 0);
    chk("rst_cpu_irq_id", bus.cpu_irq_id, 0);
    chk("rst_in_svc_id", bus.in_svc_id, 0);
    chk("rst_fifo_cnt", bus.fifo_cnt, 0);
    chk("rst_ovf", bus.ovf, 0);

    // Single pulse latency: count at cycle 1, presented at cycle 2
    push_id(5);
    chk("lat_cnt_c1", bus.fifo_cnt, 1);
    chk("lat_irq_c1", bus.cpu_irq, 0);
    tick();
    chk("lat_irq_c2", bus.cpu_irq, 1);
    chk("lat_id_c2", bus.cpu_irq_id, 5);
    do_ack();
    do_eoi();

    // In-order service of back-to-back pulses
    push_id(3);
    push_id(1);
    push_id(6);
    chk("cnt_three", bus.fifo_cnt, 3);
    for (int i = 0; i < 3; i++) begin
      do_ack();
      do_eoi();
    end

    // Fill to depth with no ACK, then overflow
    push_id(1);
    push_id(3);
    push_id(4);
    push_id(6);
    chk("full_cnt", bus.fifo_cnt, 4);
    chk("full_no_ovf", bus.ovf, 0);
    chk("full_irq_held", bus.cpu_irq, 1);
    chk("full_id_held", bus.cpu_irq_id, 1);
    push_id(7);
    chk("ovf_set", bus.ovf, 1);
    chk("ovf_cnt", bus.fifo_cnt, 4);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared", bus.ovf, 0);
    // Clear and overflow together: the set wins
    bus.ovf_clr = 1'b1;
    push_id(7);
    bus.ovf_clr = 1'b0;
    chk("ovf_set_wins", bus.ovf, 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared2", bus.ovf, 0);

    // Push and pop together while full
    id = exp_q.pop_front();
    chk("pp_present_id", bus.cpu_irq_id, id);
    bus.cpu_ack = 1'b1;
    bus.irq_vld = 1'b1;
    bus.irq_id  = 3'd2;
    exp_q.push_back(2);
    tick();
    bus.cpu_ack = 1'b0;
    bus.irq_vld = 1'b0;
    chk("pp_cnt", bus.fifo_cnt, 4);
    chk("pp_no_ovf", bus.ovf, 0);
    chk("pp_in_svc", bus.in_svc_id, id);
    do_eoi();
    for (int i = 0; i < 4; i++) begin
      do_ack();
      do_eoi();
    end
    tick();
    tick();
    chk("drain_irq_low", bus.cpu_irq, 0);
    chk("drain_cnt", bus.fifo_cnt, 0);

    // Stray handshakes: EOI in IDLE, EOI in PRESENT, EOI with ACK, ACK in SERVICE
    bus.cpu_eoi = 1'b1;
    tick();
    bus.cpu_eoi = 1'b0;
    chk("eoi_idle_irq", bus.cpu_irq, 0);
    chk("eoi_idle_svc", bus.in_svc_id, 0);
    push_id(5);
    tick();
    chk("pre_irq", bus.cpu_irq, 1);
    bus.cpu_eoi = 1'b1;
    tick();
    chk("eoi_pres_irq", bus.cpu_irq, 1);
    chk("eoi_pres_id", bus.cpu_irq_id, 5);
    chk("eoi_pres_svc", bus.in_svc_id, 0);
    bus.cpu_ack = 1'b1;
    id = exp_q.pop_front();
    tick();
    bus.cpu_eoi = 1'b0;
    chk("ackeoi_svc", bus.in_svc_id, id);
    chk("ackeoi_irq", bus.cpu_irq, 0);
    tick();
    bus.cpu_ack = 1'b0;
    chk("ack_svc_svc", bus.in_svc_id, id);
    chk("ack_svc_irq", bus.cpu_irq, 0);
    chk("ack_svc_cnt", bus.fifo_cnt, 0);
    do_eoi();

    // Reset in SERVICE with two entries queued
    push_id(1);
    push_id(2);
    push_id(3);
    do_ack();
    chk("pre_rst_cnt", bus.fifo_cnt, 2);
    rst = 1'b1;
    bus.irq_vld = 1'b1;
    bus.irq_id  = 3'd4;
    bus.cpu_ack = 1'b1;
    tick();
    rst = 1'b0;
    bus.irq_vld = 1'b0;
    bus.cpu_ack = 1'b0;
    exp_q.delete();
    chk("mrst_irq", bus.cpu_irq, 0);
    chk("mrst_id", bus.cpu_irq_id, 0);
    chk("mrst_svc", bus.in_svc_id, 0);
    chk("mrst_cnt", bus.fifo_cnt, 0);
    chk("mrst_ovf", bus.ovf, 0);
    tick();
    tick();
    tick();
    chk("mrst_no_stale", bus.cpu_irq, 0);
    chk("mrst_cnt_late", bus.fifo_cnt, 0);

    // Normal operation after reset
    push_id(6);
    do_ack();
    do_eoi();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
